// File: rtl/ram_arbiter.sv
// Two-master round-robin arbiter sharing one single-port word RAM over valid/ready.
// Optional forced-completion timeout is enabled with the RAM_ARB_TIMEOUT_EN macro.
module ram_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [3:0]  m0_wstrb,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [3:0]  m1_wstrb,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  input  logic        s_ready,
  output logic [3:0]  s_wstrb,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic [31:0] s_rdata,
  output logic        grant,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e state_q, state_d;
  logic   grant_q, grant_d;
  logic   last_q, last_d;
  logic   in_busy;
  logic   timeout_fire;
  logic   done;

  assign in_busy = (state_q == StBusy);

`ifdef RAM_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  // A real s_ready in the firing cycle wins over the timeout.
  assign timeout_fire = in_busy && !s_ready && (cnt_q == CntLast);

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (state_q == StIdle) begin
      cnt_d = '0;
    end else if (!s_ready) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (timeout_fire) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign timeout_err = err_q;
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign timeout_fire = 1'b0;
  assign timeout_err  = 1'b0;
`endif

  assign done = in_busy && (s_ready || timeout_fire);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      StIdle: begin
        if (m0_valid || m1_valid) begin
          state_d = StBusy;
          grant_d = (m0_valid && m1_valid) ? ~last_q : m1_valid;
        end
      end
      StBusy: begin
        if (done) begin
          state_d = StIdle;
          last_d  = grant_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // Slave side is zeroed outside BUSY so the RAM never sees a spurious write.
  always_comb begin
    s_valid  = 1'b0;
    s_wstrb  = 4'b0;
    s_addr   = 32'b0;
    s_wdata  = 32'b0;
    m0_ready = 1'b0;
    m1_ready = 1'b0;
    m0_rdata = 32'b0;
    m1_rdata = 32'b0;
    if (in_busy) begin
      s_valid = 1'b1;
      s_wstrb = grant_q ? m1_wstrb : m0_wstrb;
      s_addr  = grant_q ? m1_addr  : m0_addr;
      s_wdata = grant_q ? m1_wdata : m0_wdata;
    end
    if (done) begin
      if (grant_q) begin
        m1_ready = 1'b1;
        m1_rdata = s_ready ? s_rdata : 32'hDEADBEEF;
      end else begin
        m0_ready = 1'b1;
        m0_rdata = s_ready ? s_rdata : 32'hDEADBEEF;
      end
    end
  end

  assign grant = grant_q;
  assign busy  = in_busy;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural RAM that registers ready one cycle late
// and writes on any nonzero strobe.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        m0_valid, m0_ready, m1_valid, m1_ready;
  logic [3:0]  m0_wstrb, m1_wstrb, s_wstrb;
  logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
  logic        s_valid, s_ready;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic        grant, busy, timeout_err;
  logic        slave_stall;
  logic [31:0] mem [0:63];

  int n_checks = 0;
  int n_errors = 0;

  ram_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .m0_valid   (m0_valid),
    .m0_ready   (m0_ready),
    .m0_wstrb   (m0_wstrb),
    .m0_addr    (m0_addr),
    .m0_wdata   (m0_wdata),
    .m0_rdata   (m0_rdata),
    .m1_valid   (m1_valid),
    .m1_ready   (m1_ready),
    .m1_wstrb   (m1_wstrb),
    .m1_addr    (m1_addr),
    .m1_wdata   (m1_wdata),
    .m1_rdata   (m1_rdata),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_wstrb    (s_wstrb),
    .s_addr     (s_addr),
    .s_wdata    (s_wdata),
    .s_rdata    (s_rdata),
    .grant      (grant),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Slave RAM: ready echoes valid one cycle later; writes ignore valid.
  always @(posedge clk) begin
    s_ready <= slave_stall ? 1'b0 : s_valid;
    s_rdata <= mem[s_addr[7:2]];
    for (int b = 0; b < 4; b++) begin
      if (s_wstrb[b]) mem[s_addr[7:2]][8*b +: 8] <= s_wdata[8*b +: 8];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until either ready pulses or the budget runs out.
  task automatic run_until_ready(input int budget, output int cyc, output logic found,
                                 output logic r0, output logic r1,
                                 output logic [31:0] rd0, output logic [31:0] rd1);
    cyc   = 0;
    found = 1'b0;
    r0    = 1'b0;
    r1    = 1'b0;
    rd0   = '0;
    rd1   = '0;
    while (!found && cyc < budget) begin
      tick();
      cyc++;
      if (m0_ready || m1_ready) begin
        found = 1'b1;
        r0    = m0_ready;
        r1    = m1_ready;
        rd0   = m0_rdata;
        rd1   = m1_rdata;
      end
    end
  endtask

  int          cyc, abs_cyc;
  logic        found, r0, r1;
  logic [31:0] rd0, rd1;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[4]      = 32'h12345678;
    s_ready     = 1'b0;
    s_rdata     = 32'h0;
    slave_stall = 1'b0;
    resetn      = 1'b0;
    m0_valid = 1'b0; m0_wstrb = 4'h0; m0_addr = 32'h0; m0_wdata = 32'h0;
    m1_valid = 1'b0; m1_wstrb = 4'h0; m1_addr = 32'h0; m1_wdata = 32'h0;

    // Reset values before any clock edge
    #3;
    check_eq("rst_s_valid", s_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_grant", grant, 0);
    check_eq("rst_m0_ready", m0_ready, 0);
    check_eq("rst_timeout_err", timeout_err, 0);
    tick();
    tick();
    resetn = 1'b1;

    // m0 read of 0x10
    m0_valid = 1'b1;
    m0_addr  = 32'h10;
    check_eq("rd_c0_s_valid", s_valid, 0);
    tick();
    check_eq("rd_c1_s_valid", s_valid, 1);
    check_eq("rd_c1_m0_ready", m0_ready, 0);
    check_eq("rd_c1_s_addr", s_addr, 32'h10);
    tick();
    check_eq("rd_c2_m0_ready", m0_ready, 1);
    check_eq("rd_c2_m0_rdata", m0_rdata, 32'h12345678);
    check_eq("rd_c2_m1_ready", m1_ready, 0);
    m0_valid = 1'b0;
    tick();
    check_eq("rd_c3_m0_ready", m0_ready, 0);
    check_eq("rd_c3_busy", busy, 0);

    // m1 partial write to 0x20
    m1_valid = 1'b1;
    m1_wstrb = 4'b0011;
    m1_addr  = 32'h20;
    m1_wdata = 32'hAABBCCDD;
    check_eq("wr_idle_s_wstrb", s_wstrb, 0);
    tick();
    check_eq("wr_c1_grant", grant, 1);
    check_eq("wr_c1_s_wstrb", s_wstrb, 4'b0011);
    check_eq("wr_c1_s_wdata", s_wdata, 32'hAABBCCDD);
    tick();
    check_eq("wr_c2_m1_ready", m1_ready, 1);
    check_eq("wr_c2_m0_ready", m0_ready, 0);
    check_eq("wr_c2_m0_rdata", m0_rdata, 0);
    m1_valid = 1'b0;
    m1_wstrb = 4'h0;
    tick();
    check_eq("wr_c3_s_wstrb", s_wstrb, 0);

    // Read back through m0
    m0_valid = 1'b1;
    m0_addr  = 32'h20;
    run_until_ready(10, cyc, found, r0, r1, rd0, rd1);
    check_eq("rb_found", found, 1);
    check_eq("rb_latency", cyc, 2);
    check_eq("rb_m0_ready", r0, 1);
    check_eq("rb_m0_rdata", rd0, 32'h0000CCDD);
    m0_valid = 1'b0;
    tick();

    // Both masters held valid from reset: strict alternation, pulses at cycles 2,5,8,11
    resetn = 1'b0;
    tick();
    resetn   = 1'b1;
    m0_valid = 1'b1;
    m0_addr  = 32'h10;
    m1_valid = 1'b1;
    m1_addr  = 32'h20;
    abs_cyc  = 0;
    for (int k = 0; k < 4; k++) begin
      run_until_ready(10, cyc, found, r0, r1, rd0, rd1);
      abs_cyc += cyc;
      check_eq($sformatf("rr%0d_found", k), found, 1);
      check_eq($sformatf("rr%0d_readies", k), {30'b0, r1, r0}, (k % 2 == 0) ? 2 'b01 : 2'b10);
      check_eq($sformatf("rr%0d_cycle", k), abs_cyc, 2 + 3 * k);
      tick();
      abs_cyc++;
      // Stale slave ready lands in this IDLE cycle and must not complete anything
      check_eq($sformatf("rr%0d_idle_readies", k), {30'b0, m1_ready, m0_ready}, 0);
      check_eq($sformatf("rr%0d_idle_busy", k), busy, 0);
    end
    m0_valid = 1'b0;
    m1_valid = 1'b0;
    tick();

    // Async reset in the middle of an m1 transaction
    m1_valid = 1'b1;
    tick();
    check_eq("ar_c1_grant", grant, 1);
    #2;
    resetn = 1'b0;
    #1;
    check_eq("ar_s_valid", s_valid, 0);
    check_eq("ar_busy", busy, 0);
    check_eq("ar_grant", grant, 0);
    check_eq("ar_m1_ready", m1_ready, 0);
    m1_valid = 1'b0;
    tick();
    resetn   = 1'b1;
    m0_valid = 1'b1;
    m1_valid = 1'b1;
    tick();
    check_eq("ar_tie_grant", grant, 0);
    check_eq("ar_tie_busy", busy, 1);
    run_until_ready(10, cyc, found, r0, r1, rd0, rd1);
    check_eq("ar_tie_m0_ready", {30'b0, r1, r0}, 2'b01);
    m0_valid = 1'b0;
    m1_valid = 1'b0;
    tick();

    // Stalled slave
    slave_stall = 1'b1;
    m0_valid    = 1'b1;
    m0_addr     = 32'h10;
    run_until_ready(20, cyc, found, r0, r1, rd0, rd1);
`ifdef RAM_ARB_TIMEOUT_EN
    check_eq("to_found", found, 1);
    check_eq("to_cycle", cyc, 8);
    check_eq("to_m0_rdata", rd0, 32'hDEADBEEF);
    m0_valid = 1'b0;
    tick();
    check_eq("to_err_set", timeout_err, 1);
    tick();
    tick();
    check_eq("to_err_sticky", timeout_err, 1);
`else
    check_eq("nto_no_ready", found, 0);
    check_eq("nto_busy", busy, 1);
    check_eq("nto_timeout_err", timeout_err, 0);
`endif
    m0_valid = 1'b0;
    resetn   = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
